// File: rtl/sparse_index_encoder.sv
// Zero-run-length sparse encoder: packs up to LANES nonzero activations per beat with run indices.
// Optional fused ReLU (negatives treated as zero) is enabled by defining SPARSE_ENC_RELU_EN.
module sparse_index_encoder #(
  parameter int DATA_W = 16,
  parameter int LANES  = 4,
  parameter int IDX_W  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      frame_restart,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_W-1:0]         in_data,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*DATA_W-1:0]   out_data,
  output logic [LANES*IDX_W-1:0]    out_index,
  output logic [LANES-1:0]          out_mask,
  output logic                      out_last,
  output logic [15:0]               nnz_count
);

  localparam int CW = $clog2(LANES + 1);
  localparam logic [IDX_W-1:0] RUN_MAX = '1;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] PACK = 1'b1;

  logic [0:0]                     state_q, state_d;
  logic [IDX_W-1:0]               run_q, run_d;
  logic [CW-1:0]                  cnt_q, cnt_d;
  logic [LANES-1:0][DATA_W-1:0]   bufData_q, bufData_d;
  logic [LANES-1:0][IDX_W-1:0]    bufIdx_q, bufIdx_d;
  logic [LANES-1:0][DATA_W-1:0]   packData;
  logic [LANES-1:0][IDX_W-1:0]    packIdx;
  logic [LANES-1:0]               packMask;
  logic [LANES-1:0][DATA_W-1:0]   outData_q;
  logic [LANES-1:0][IDX_W-1:0]    outIdx_q;
  logic [LANES-1:0]               outMask_q;
  logic                           outValid_q, outLast_q;
  logic [15:0]                    nnz_q, nnz_d, nnzBase;
  logic                           clearPend_q, clearPend_d;
  logic                           accept, isZero, runWrap, append, load;
  logic [CW-1:0]                  newCnt;

  assign in_ready  = !outValid_q || out_ready;
  assign out_valid = outValid_q;
  assign out_data  = outData_q;
  assign out_index = outIdx_q;
  assign out_mask  = outMask_q;
  assign out_last  = outLast_q;
  assign nnz_count = nnz_q;

  // A zero on the final element never becomes a filler entry: trailing zeros are not encoded.
  always_comb begin
    accept = in_valid && in_ready && !frame_restart;
`ifdef SPARSE_ENC_RELU_EN
    isZero = (in_data == '0) || in_data[DATA_W-1];
`else
    isZero = (in_data == '0);
`endif
    runWrap = accept && isZero && (run_q == RUN_MAX) && !in_last;
    append  = accept && (!isZero || runWrap);
    newCnt  = cnt_q + CW'(append);
    load    = accept && ((newCnt == CW'(LANES)) || in_last);

    packData = bufData_q;
    packIdx  = bufIdx_q;
    packMask = '0;
    for (int i = 0; i < LANES; i++) begin
      if (append && (cnt_q == CW'(i))) begin
        packData[i] = isZero ? '0 : in_data;
        packIdx[i]  = run_q;
      end
      packMask[i] = (CW'(i) < newCnt);
    end
  end

  always_comb begin
    state_d     = state_q;
    run_d       = run_q;
    cnt_d       = cnt_q;
    bufData_d   = bufData_q;
    bufIdx_d    = bufIdx_q;
    nnz_d       = nnz_q;
    clearPend_d = clearPend_q;
    nnzBase     = clearPend_q ? 16'h0000 : nnz_q;
    if (frame_restart) begin
      state_d     = IDLE;
      run_d       = '0;
      cnt_d       = '0;
      bufData_d   = '0;
      bufIdx_d    = '0;
      nnz_d       = '0;
      clearPend_d = 1'b0;
    end else if (accept) begin
      nnz_d       = (append && (nnzBase != 16'hFFFF)) ? nnzBase + 16'd1 : nnzBase;
      clearPend_d = load && in_last;
      state_d     = (load && in_last) ? IDLE : PACK;
      if ((load && in_last) || !isZero || runWrap) run_d = '0;
      else                                       run_d = run_q + 1'b1;
      if (load) begin
        cnt_d     = '0;
        bufData_d = '0;
        bufIdx_d  = '0;
      end else begin
        cnt_d     = newCnt;
        bufData_d = packData;
        bufIdx_d  = packIdx;
      end
    end
  end

  // The output register only reloads when free or being drained on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      run_q       <= '0;
      cnt_q       <= '0;
      bufData_q   <= '0;
      bufIdx_q    <= '0;
      nnz_q       <= '0;
      clearPend_q <= 1'b0;
      outValid_q  <= 1'b0;
      outLast_q   <= 1'b0;
      outMask_q   <= '0;
      outData_q   <= '0;
      outIdx_q    <= '0;
    end else begin
      state_q     <= state_d;
      run_q       <= run_d;
      cnt_q       <= cnt_d;
      bufData_q   <= bufData_d;
      bufIdx_q    <= bufIdx_d;
      nnz_q       <= nnz_d;
      clearPend_q <= clearPend_d;
      if (load) begin
        outValid_q <= 1'b1;
        outLast_q  <= in_last;
        outMask_q  <= packMask;
        outData_q  <= packData;
        outIdx_q   <= packIdx;
      end else if (outValid_q && out_ready) begin
        outValid_q <= 1'b0;
      end
    end
  end

endmodule
